wave_decoder: RTL and testbench



---
 rtl/wave_decoder.sv | 110 +++++++++++
 tb/tb_wave_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wave_decoder.sv
// wave_decoder: frame-aligning receiver for the 8-symbol wave line (sync 1000101 + data bit).
module wave_decoder #(
  parameter int LOCK_FRAMES   = 2,
  parameter int UNLOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  localparam logic [3:0] UF = 4'(UNLOCK_FRAMES);
  state_t state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] good_q, good_d, bad_q, bad_d;
  logic data_out_q, data_out_d, data_valid_q, data_valid_d;
  logic locked_q, locked_d, sync_err_q, sync_err_d;
  logic [7:0] err_count_q, err_count_d;
  logic match, boundary;
  always_comb begin
    sr_d         = {sr_q[6:0], din};
    match        = sr_d[7:1] == 7'b1000101;
    boundary     = (state_q != HUNT) && (phase_q == 3'd7);
    state_d      = state_q;
    phase_d      = phase_q + 3'd1;
    good_d       = good_q;
    bad_d        = bad_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    case (state_q)
      HUNT: if (match) begin
        phase_d = 3'd0;
        good_d  = 4'd1;
        bad_d   = 4'd0;
        if (LF == 4'd1) begin
          state_d      = LOCKED;
          data_out_d   = sr_d[0];
          data_valid_d = 1'b1;
        end else begin
          state_d = VERIFY;
        end
      end
      VERIFY: if (boundary) begin
        if (match) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == LF) begin
            state_d      = LOCKED;
            bad_d        = 4'd0;
            data_out_d   = sr_d[0];
            data_valid_d = 1'b1;
          end
        end else begin
          sync_err_d = 1'b1;
          state_d    = HUNT;
        end
      end
      LOCKED: if (boundary) begin
        if (match) begin
          data_out_d   = sr_d[0];
          data_valid_d = 1'b1;
          bad_d        = 4'd0;
        end else begin
          sync_err_d = 1'b1;
          bad_d      = bad_q + 4'd1;
          state_d    = (bad_q + 4'd1 == UF) ? HUNT : LOCKED;
        end
      end
      default: state_d = HUNT;
    endcase
    locked_d    = state_d == LOCKED;
    err_count_d = (sync_err_d && err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      phase_q      <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      phase_q      <= phase_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
      err_count_q  <= err_count_d;
    end
  end
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
  assign err_count  = err_count_q;
endmodule

// File: tb/tb_wave_decoder.sv
// tb_wave_decoder: random frame streams against a frame-level reference model with queued expectations.
module tb_wave_decoder;
  localparam int LF = 2;
  localparam int UF = 2;
  localparam logic [6:0] SYNC = 7'b1000101;
  logic clk = 1'b0;
  logic rst, din;
  logic data_out, data_valid, locked, sync_err;
  logic [7:0] err_count;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  wave_decoder dut (
    .clk(clk), .rst(rst), .din(din),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .sync_err(sync_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int e;
    logic lk, se, dout;
    logic [7:0] ec;
  } st_t;
  st_t stq[$];
  int sq[$];
  int hist[$];
  int mode, anchor, good, bad, m_err;
  logic m_dout;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, x);
    end
  endtask
  // Expected outputs after edge e, given the symbol and reset seen at that edge.
  task automatic step(input int e, input logic d, input logic r);
    logic m, se, dv;
    m = 1'b0; se = 1'b0; dv = 1'b0;
    if (r) begin
      hist.delete();
      mode = 0; good = 0; bad = 0; m_err = 0; m_dout = 1'b0;
    end else begin
      hist.push_back(int'(d));
      if (hist.size() > 8) void'(hist.pop_front());
      if (hist.size() == 8) begin
        m = 1'b1;
        for (int i = 0; i < 7; i++) if (hist[i] != int'(SYNC[6-i])) m = 1'b0;
      end
      if (mode == 0) begin
        if (m) begin
          anchor = e; good = 1; bad = 0;
          if (good == LF) begin mode = 2; dv = 1'b1; end else mode = 1;
        end
      end else if ((e - anchor) % 8 == 0) begin
        if (!m) begin
          se = 1'b1;
          if (mode == 1) mode = 0;
          else begin bad++; if (bad == UF) mode = 0; end
        end else begin
          anchor = e;
          if (mode == 1) begin
            good++;
            if (good == LF) begin mode = 2; bad = 0; dv = 1'b1; end
          end else begin
            bad = 0; dv = 1'b1;
          end
        end
      end
      if (dv) m_dout = d;
      if (se && m_err < 255) m_err++;
    end
    if (dv) sq.push_back(e);
    stq.push_back('{e, mode == 2, se, m_dout, 8'(m_err)});
  endtask
  task automatic send(input logic d, input logic r);
    din = d; rst = r;
    step(cyc + 1, d, r);
    @(posedge clk); #1;
  endtask
  task automatic frame(input int flip, input logic d);
    for (int i = 0; i < 7; i++) send(SYNC[6-i] ^ logic'(i == flip), 1'b0);
    send(d, 1'b0);
  endtask
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  always @(negedge clk) begin
    st_t x;
    logic exp_dv;
    if (stq.size() == 0) chk("expect_queue_underflow", 0, 1);
    else begin
      x = stq.pop_front();
      chk("edge_index", cyc, x.e);
      chk("locked", {31'd0, locked}, {31'd0, x.lk});
      chk("sync_err", {31'd0, sync_err}, {31'd0, x.se});
      chk("data_out", {31'd0, data_out}, {31'd0, x.dout});
      chk("err_count", {24'd0, err_count}, {24'd0, x.ec});
    end
    exp_dv = sq.size() > 0 && sq[0] == cyc;
    if (data_valid || exp_dv) begin
      chk("data_valid", {31'd0, data_valid}, {31'd0, exp_dv});
      if (exp_dv) void'(sq.pop_front());
    end
  end
  initial begin
    rst = 1'b1; din = 1'b0;
    step(1, 1'b0, 1'b1);
    @(posedge clk); #1;
    send(1'b0, 1'b1);
    frame(-1, 1'b1); frame(-1, 1'b0); frame(-1, 1'b1); frame(-1, 1'b1);
    repeat (4) frame(-1, rb());
    send(1'b0, 1'b1);
    for (int i = 3; i < 7; i++) send(SYNC[6-i], 1'b0);
    send(rb(), 1'b0);
    repeat (5) frame(-1, rb());
    frame(2, rb());
    repeat (3) frame(-1, rb());
    frame(int'($urandom_range(0, 6)), rb());
    frame(int'($urandom_range(0, 6)), rb());
    repeat (4) frame(-1, rb());
    repeat (30) frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1, rb());
    for (int i = 0; i < int'($urandom_range(0, 6)); i++) send(SYNC[6-i], 1'b0);
    send(1'b0, 1'b1);
    repeat (4) frame(-1, rb());
    send(1'b0, 1'b1);
    repeat (64) send(1'b1, 1'b0);
    repeat (64) send(1'b0, 1'b0);
    for (int i = 0; i < 64; i++) send(logic'(i % 2), 1'b0);
    repeat (300) send(rb(), 1'b0);
    send(1'b0, 1'b1);
    repeat (270) begin
      frame(-1, rb());
      frame(int'($urandom_range(0, 6)), rb());
    end
    repeat (4) frame(-1, rb());
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    @(negedge clk); #1;
    chk("pending_states", stq.size(), 0);
    chk("pending_strobes", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
